div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_ctrl_step.sv | 28 ++
 rtl/div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, result bus
// width and the start/stop levels seen on start_i.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } div_state_t;

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // {remainder, quotient} bus width for a given operand width
   function automatic int unsigned div_result_bus(input int unsigned data_w);
      return 2 * data_w;
   endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in the quotient bit.
module div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic [DATA_W-1:0] quo_next
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      shifted = {rem, quo[DATA_W-1]};
      diff    = shifted - {1'b0, divisor};
      // a clear borrow bit means the divisor fits into the shifted remainder
      if (!diff[DATA_W]) begin
         rem_next = diff[DATA_W-1:0];
      end else begin
         rem_next = shifted[DATA_W-1:0];
      end
      quo_next = {quo[DATA_W-2:0], ~diff[DATA_W]};
   end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller with pipeline stall handshake.
// Define DIV_CTRL_SIGNED_EN to honour signed_i (signed DIV); otherwise all unsigned.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start_i,
   input  logic                                annul_i,
   input  logic                                signed_i,
   input  logic [DATA_W-1:0]                   opdata1_i,
   input  logic [DATA_W-1:0]                   opdata2_i,
   output logic [div_result_bus(DATA_W)-1:0]   result_o,
   output logic                                ready_o,
   output logic                                stallreq_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
   localparam int unsigned RES_W = div_result_bus(DATA_W);

   div_state_t         state;
   div_state_t         state_next;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  rem_q;
   logic [DATA_W-1:0]  quo_q;
   logic [DATA_W-1:0]  divisor_q;
   logic [DATA_W-1:0]  rem_step;
   logic [DATA_W-1:0]  quo_step;
   logic [DATA_W-1:0]  op1_abs;
   logic [DATA_W-1:0]  op2_abs;
   logic [DATA_W-1:0]  quo_fin;
   logic [DATA_W-1:0]  rem_fin;
   logic               accept;
   logic               steps_done;
   logic               ready_d;
   logic [RES_W-1:0]   result_d;

   assign accept     = (state == IDLE) && (start_i == DIV_START) && !annul_i;
   assign steps_done = (cnt == CNT_W'(DATA_W));
   assign stallreq_o = start_i & ~ready_o & ~annul_i;

`ifdef DIV_CTRL_SIGNED_EN
   logic sign1;
   logic sign2;
   logic neg_quo_q;
   logic neg_rem_q;

   assign sign1   = signed_i & opdata1_i[DATA_W-1];
   assign sign2   = signed_i & opdata2_i[DATA_W-1];
   assign op1_abs = sign1 ? -opdata1_i : opdata1_i;
   assign op2_abs = sign2 ? -opdata2_i : opdata2_i;
   // quotient negative on differing signs, remainder follows the dividend
   assign quo_fin = neg_quo_q ? -quo_q : quo_q;
   assign rem_fin = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (accept) begin
         neg_quo_q <= sign1 ^ sign2;
         neg_rem_q <= sign1;
      end
   end
`else
   logic signed_unused;

   assign signed_unused = signed_i;
   assign op1_abs       = opdata1_i;
   assign op2_abs       = opdata2_i;
   assign quo_fin       = quo_q;
   assign rem_fin       = rem_q;
`endif

   div_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (divisor_q),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_next = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
            end
         end
         DIV_ZERO: state_next = annul_i ? IDLE : DIV_END;
         DIV_ON: begin
            if (annul_i) begin
               state_next = IDLE;
            end else if (steps_done) begin
               state_next = DIV_END;
            end
         end
         DIV_END: begin
            if (annul_i || (start_i == DIV_STOP)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_d  = 1'b0;
      result_d = '0;
      unique case (state)
         DIV_ZERO: ready_d = !annul_i;
         DIV_ON: begin
            if (!annul_i && steps_done) begin
               ready_d  = 1'b1;
               result_d = {rem_fin, quo_fin};
            end
         end
         DIV_END: begin
            if (!annul_i && (start_i == DIV_START)) begin
               ready_d  = 1'b1;
               result_d = result_o;
            end
         end
         default: begin
            ready_d  = 1'b0;
            result_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_o  <= 1'b0;
         result_o <= '0;
      end else begin
         ready_o  <= ready_d;
         result_o <= result_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
      end else if (accept && (opdata2_i != '0)) begin
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= op1_abs;
         divisor_q <= op2_abs;
      end else if ((state == DIV_ON) && !annul_i && !steps_done) begin
         cnt   <= cnt + CNT_W'(1);
         rem_q <= rem_step;
         quo_q <= quo_step;
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed, table-driven self-checking bench for div_ctrl (DATA_W = 32).
// Expectations follow DIV_CTRL_SIGNED_EN the same way the design build does.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          edges;
      bit          end_by_annul;
   } vec_t;

   vec_t vecs[10];

   div_ctrl #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .annul_i    (annul_i),
      .signed_i   (signed_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .stallreq_o (stallreq_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge with the DUT in IDLE; edges counted after accept
   task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_edges,
                         input bit end_by_annul, input bit check_stall);
      int edges;
      int stall;
      signed_i  = sgn;
      opdata1_i = a;
      opdata2_i = b;
      start_i   = 1'b1;
      @(posedge clk); #1;
      signed_i  = ~sgn;
      opdata1_i = ~a;
      opdata2_i = b ^ 32'h5A5A_0F0F;
      edges = 0;
      stall = 0;
      while (!ready_o && edges < 60) begin
         if (stallreq_o) stall++;
         @(posedge clk); #1;
         edges++;
      end
      check({name, "_latency"}, 64'(edges), 64'(exp_edges));
      check({name, "_result"}, result_o, exp);
      if (check_stall) check({name, "_stall_cycles"}, 64'(stall), 64'd33);
      @(posedge clk); #1;
      check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({name, "_hold_result"}, result_o, exp);
      if (end_by_annul) annul_i = 1'b1;
      else start_i = 1'b0;
      @(posedge clk); #1;
      check({name, "_clear_ready"}, 64'(ready_o), 64'd0);
      check({name, "_clear_result"}, result_o, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
   endtask

   initial begin
      bit ready_seen;

      vecs[0] = '{1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 33, 1'b0};
`ifdef DIV_CTRL_SIGNED_EN
      vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33, 1'b0};
      vecs[7] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 33, 1'b0};
      vecs[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 33, 1'b0};
`else
      vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h0000_0001, 33, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0};
      vecs[7] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0007, 33, 1'b0};
      vecs[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FF9C, 33, 1'b0};
`endif
      vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1};
      vecs[4] = '{1'b0, 32'd5, 32'd10, 32'h0000_0000, 32'h0000_0005, 33, 1'b0};
      vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 33, 1'b0};
      vecs[6] = '{1'b0, 32'h1234_5678, 32'd1000, 32'h0004_A90B, 32'h0000_0380, 33, 1'b0};
      vecs[9] = '{1'b0, 32'd77, 32'd0, 32'h0000_0000, 32'h0000_0000, 1, 1'b0};

      rst       = 1'b0;
      start_i   = 1'b0;
      annul_i   = 1'b0;
      signed_i  = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      #12;
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_stall_idle", 64'(stallreq_o), 64'd0);
      start_i = 1'b1;
      #1;
      check("reset_stall_start", 64'(stallreq_o), 64'd1);
      start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_reset_ready", 64'(ready_o), 64'd0);

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                {vecs[i].r, vecs[i].q}, vecs[i].edges, vecs[i].end_by_annul, i == 0);
      end

      // annul partway through a long division, then restart at once
      signed_i  = 1'b0;
      opdata1_i = 32'hFFFF_FFFF;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      @(posedge clk); #1;
      ready_seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ready_o) ready_seen = 1'b1;
      end
      annul_i = 1'b1;
      #1;
      check("annul_stall_low", 64'(stallreq_o), 64'd0);
      @(posedge clk); #1;
      check("annul_ready", 64'(ready_o), 64'd0);
      check("annul_result", result_o, 64'd0);
      check("annul_no_ready_before", 64'(ready_seen), 64'd0);
      annul_i = 1'b0;
      run_op("annul_restart", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0, 1'b0);

      // reset mid-division discards the operation
      opdata1_i = 32'hDEAD_BEEF;
      opdata2_i = 32'd17;
      start_i   = 1'b1;
      @(posedge clk); #1;
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_ready", 64'(ready_o), 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      ready_seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o) ready_seen = 1'b1;
      end
      check("rst_mid_no_ready", 64'(ready_seen), 64'd0);

      // reset while a result is being held clears it asynchronously
      signed_i  = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      repeat (36) @(posedge clk);
      #1;
      check("end_hold_before_rst", result_o, {32'd2, 32'd14});
      #2;
      rst = 1'b0;
      #1;
      check("rst_end_ready", 64'(ready_o), 64'd0);
      check("rst_end_result", result_o, 64'd0);
      start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_op("after_rst", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
